exception_ctrl: RTL and testbench

- Sequencer that owns the PC path during exceptions and ERET.
- On an exception it saves the faulting PC into EPC and fetches the handler address from the fixed vector byte in memory. It then drives the PC-source select and pc_write to load that address.
- On ERET it drives the select to the EPC path.
- Sits beside the main control FSM, which stalls while busy is high and yields PC-source ownership whenever pcsrc_own is high.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/exception_ctrl.sv | 154 +++++++++++++++
 tb/tb_exception_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state, cause, PC-source and vector constants
// Purpose: types and constants shared by the exception sequencer and the main control.
// Ports: none (package).
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAVE   = 3'd1,
    ST_VREQ   = 3'd2,
    ST_VWAIT  = 3'd3,
    ST_LOAD   = 3'd4,
    ST_RETURN = 3'd5
  } exc_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_OPCODE = 2'd1,
    CAUSE_OVF    = 2'd2,
    CAUSE_DIV0   = 2'd3
  } exc_cause_e;

  localparam logic [2:0] PCSRC_LOAD   = 3'd0;
  localparam logic [2:0] PCSRC_ALU    = 3'd1;
  localparam logic [2:0] PCSRC_ALUOUT = 3'd2;
  localparam logic [2:0] PCSRC_JUMP   = 3'd3;
  localparam logic [2:0] PCSRC_EPC    = 3'd4;

  localparam logic [31:0] VEC_OPCODE_DEF = 32'd253;
  localparam logic [31:0] VEC_OVF_DEF    = 32'd254;
  localparam logic [31:0] VEC_DIV0_DEF   = 32'd255;

endpackage

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - exception / ERET sequencer owning the PC path
// Purpose: saves EPC, fetches the handler vector from memory and loads it into
//          the PC; on ERET selects the EPC path for one PC write.
// Ports:
//   clk, reset (async, active-low)
//   exc_opcode/exc_overflow/exc_divzero/eret : single-cycle requests
//   pc_in        : current (already incremented) PC
//   epc_out      : saved exception PC
//   mem_addr/mem_addr_sel : vector fetch address and ownership strobe
//   pcsrc/pcsrc_own/pc_write : PC-source select, override, load enable
//   busy         : main control stalls while high
//   exc_cause    : last accepted cause; exc_lost : sticky dropped-request flag
module exception_ctrl
  import cpu_pkg::*;
#(
  parameter int          MEM_LAT    = 1,
  parameter logic [31:0] VEC_OPCODE = VEC_OPCODE_DEF,
  parameter logic [31:0] VEC_OVF    = VEC_OVF_DEF,
  parameter logic [31:0] VEC_DIV0   = VEC_DIV0_DEF,
  parameter logic [31:0] PC_OFFSET  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_divzero,
  input  logic        eret,
  input  logic [31:0] pc_in,
  output logic [31:0] epc_out,
  output logic [31:0] mem_addr,
  output logic        mem_addr_sel,
  output logic [2:0]  pcsrc,
  output logic        pcsrc_own,
  output logic        pc_write,
  output logic        busy,
  output logic [1:0]  exc_cause,
  output logic        exc_lost
);

  exc_state_e  state_q;
  logic [2:0]  cnt_q;
  logic [31:0] epc_q;
  logic [31:0] mem_addr_q;
  logic        mem_addr_sel_q;
  logic [2:0]  pcsrc_q;
  logic        pcsrc_own_q;
  logic        pc_write_q;
  logic        busy_q;
  exc_cause_e  cause_q;
  logic        lost_q;

  logic any_exc;
  logic any_req;
  logic [31:0] vec_addr;

  assign any_exc = exc_opcode | exc_overflow | exc_divzero;
  assign any_req = any_exc | eret;

  always_comb begin
    vec_addr = VEC_OPCODE;
    case (cause_q)
      CAUSE_OVF:  vec_addr = VEC_OVF;
      CAUSE_DIV0: vec_addr = VEC_DIV0;
      default:    vec_addr = VEC_OPCODE;
    endcase
  end

  // Outputs are registered alongside the state: each branch sets the strobes
  // for the state being entered, so they line up with the state decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      epc_q          <= '0;
      mem_addr_q     <= '0;
      mem_addr_sel_q <= 1'b0;
      pcsrc_q        <= PCSRC_LOAD;
      pcsrc_own_q    <= 1'b0;
      pc_write_q     <= 1'b0;
      busy_q         <= 1'b0;
      cause_q        <= CAUSE_NONE;
      lost_q         <= 1'b0;
    end else begin
      pcsrc_q     <= PCSRC_LOAD;
      pcsrc_own_q <= 1'b0;
      pc_write_q  <= 1'b0;
      if (state_q != ST_IDLE && any_req) begin
        lost_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (any_exc) begin
            // Priority opcode > overflow > divzero; a coincident eret is dropped.
            if (exc_opcode)        cause_q <= CAUSE_OPCODE;
            else if (exc_overflow) cause_q <= CAUSE_OVF;
            else                   cause_q <= CAUSE_DIV0;
            state_q <= ST_SAVE;
            busy_q  <= 1'b1;
          end else if (eret) begin
            state_q     <= ST_RETURN;
            busy_q      <= 1'b1;
            pcsrc_q     <= PCSRC_EPC;
            pcsrc_own_q <= 1'b1;
            pc_write_q  <= 1'b1;
          end
        end
        ST_SAVE: begin
          epc_q          <= pc_in - PC_OFFSET;
          mem_addr_q     <= vec_addr;
          mem_addr_sel_q <= 1'b1;
          state_q        <= ST_VREQ;
        end
        ST_VREQ: begin
          cnt_q   <= 3'(MEM_LAT);
          state_q <= ST_VWAIT;
        end
        ST_VWAIT: begin
          // Stays MEM_LAT cycles: leaves on the cycle the count reaches zero.
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q     <= ST_LOAD;
            pcsrc_own_q <= 1'b1;
            pc_write_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          state_q        <= ST_IDLE;
          mem_addr_sel_q <= 1'b0;
          busy_q         <= 1'b0;
        end
        ST_RETURN: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q        <= ST_IDLE;
          mem_addr_sel_q <= 1'b0;
          busy_q         <= 1'b0;
        end
      endcase
    end
  end

  assign epc_out      = epc_q;
  assign mem_addr     = mem_addr_q;
  assign mem_addr_sel = mem_addr_sel_q;
  assign pcsrc        = pcsrc_q;
  assign pcsrc_own    = pcsrc_own_q;
  assign pc_write     = pc_write_q;
  assign busy         = busy_q;
  assign exc_cause    = cause_q;
  assign exc_lost     = lost_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - directed self-checking bench for exception_ctrl
module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        exc_opcode = 1'b0;
  logic        exc_overflow = 1'b0;
  logic        exc_divzero = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] pc_in = '0;

  logic [31:0] epc1, mem_addr1, epc3, mem_addr3;
  logic        sel1, own1, pw1, busy1, lost1;
  logic        sel3, own3, pw3, busy3, lost3;
  logic [2:0]  pcsrc1, pcsrc3;
  logic [1:0]  cause1, cause3;

  int checks = 0;
  int failures = 0;

  exception_ctrl #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .exc_opcode(exc_opcode), .exc_overflow(exc_overflow),
    .exc_divzero(exc_divzero), .eret(eret), .pc_in(pc_in), .epc_out(epc1),
    .mem_addr(mem_addr1), .mem_addr_sel(sel1), .pcsrc(pcsrc1), .pcsrc_own(own1),
    .pc_write(pw1), .busy(busy1), .exc_cause(cause1), .exc_lost(lost1)
  );

  exception_ctrl #(.MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .exc_opcode(exc_opcode), .exc_overflow(exc_overflow),
    .exc_divzero(exc_divzero), .eret(eret), .pc_in(pc_in), .epc_out(epc3),
    .mem_addr(mem_addr3), .mem_addr_sel(sel3), .pcsrc(pcsrc3), .pcsrc_own(own3),
    .pc_write(pw3), .busy(busy3), .exc_cause(cause3), .exc_lost(lost3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    exc_opcode   = 1'b0;
    exc_overflow = 1'b0;
    exc_divzero  = 1'b0;
    eret         = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Cycles from the request edge until each instance raises pc_write (0 = never).
  task automatic run_to_write(output int n1, output int n3);
    n1 = 0;
    n3 = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 1) clear_req();
      if (pw1 && n1 == 0) n1 = i;
      if (pw3 && n3 == 0) n3 = i;
      if (n1 != 0 && n3 != 0) break;
    end
  endtask

  initial begin
    int n1, n3;
    logic wrote;

    #12;
    check("rst_epc", epc1, 32'h0);
    check("rst_cause", {30'b0, cause1}, 32'd0);
    check("rst_lost", {31'b0, lost1}, 32'd0);
    check("rst_mem_addr", mem_addr1, 32'd0);
    check("rst_strobes", {28'b0, pw1, sel1, own1, busy1}, 32'd0);
    check("rst_pcsrc", {29'b0, pcsrc1}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    step();

    // Overflow exception, MEM_LAT=1 instance walked cycle by cycle.
    exc_overflow = 1'b1;
    pc_in = 32'h40;
    step();
    clear_req();
    check("t1_busy_save", {31'b0, busy1}, 32'd1);
    check("t1_nowrite_save", {31'b0, pw1}, 32'd0);
    step();
    check("t1_epc", epc1, 32'h3C);
    check("t1_mem_addr", mem_addr1, 32'd254);
    check("t1_sel", {31'b0, sel1}, 32'd1);
    step();
    check("t1_nowrite_wait", {31'b0, pw1}, 32'd0);
    step();
    check("t1_pc_write", {31'b0, pw1}, 32'd1);
    check("t1_pcsrc", {29'b0, pcsrc1}, 32'd0);
    check("t1_own", {31'b0, own1}, 32'd1);
    check("t1_cause", {30'b0, cause1}, 32'd2);
    check("t1_sel_load", {31'b0, sel1}, 32'd1);
    step();
    check("t1_idle", {29'b0, busy1, pw1, own1}, 32'd0);
    idle(4);

    // Simultaneous requests: opcode wins, eret dropped.
    exc_opcode  = 1'b1;
    exc_divzero = 1'b1;
    eret        = 1'b1;
    pc_in = 32'h100;
    run_to_write(n1, n3);
    check("t2_lat1", n1, 32'd4);
    check("t2_lat3", n3, 32'd6);
    check("t2_cause", {30'b0, cause1}, 32'd1);
    check("t2_mem_addr", mem_addr1, 32'd253);
    check("t2_epc", epc1, 32'hFC);
    check("t2_lost", {31'b0, lost1}, 32'd0);
    idle(3);

    // ERET after the exception.
    eret = 1'b1;
    step();
    clear_req();
    check("t3_pcsrc", {29'b0, pcsrc1}, 32'd4);
    check("t3_write", {30'b0, pw1, own1}, 32'd3);
    check("t3_epc", epc1, 32'hFC);
    step();
    check("t3_one_shot", {30'b0, pw1, busy1}, 32'd0);
    idle(2);

    // Request during VWAIT is lost.
    exc_opcode = 1'b1;
    pc_in = 32'h200;
    step();
    clear_req();
    step();
    step();
    exc_divzero = 1'b1;
    step();
    clear_req();
    check("t4_lost", {31'b0, lost1}, 32'd1);
    check("t4_cause", {30'b0, cause1}, 32'd1);
    check("t4_epc", epc1, 32'h1FC);
    check("t4_write", {31'b0, pw1}, 32'd1);
    step();
    check("t4_done", {31'b0, busy1}, 32'd0);
    idle(5);

    // Asynchronous reset during VWAIT.
    exc_overflow = 1'b1;
    pc_in = 32'h80;
    step();
    clear_req();
    step();
    step();
    #2 reset = 1'b0;
    #1;
    check("t5_strobes", {27'b0, busy1, pw1, sel1, busy3, sel3}, 32'd0);
    check("t5_epc", epc1, 32'h0);
    check("t5_lost", {30'b0, lost1, lost3}, 32'd0);
    step();
    reset = 1'b1;
    wrote = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      wrote = wrote | pw1 | pw3;
    end
    check("t5_no_write", {31'b0, wrote}, 32'd0);

    // ERET with no prior exception loads EPC as-is.
    eret = 1'b1;
    step();
    clear_req();
    check("t6_pcsrc", {29'b0, pcsrc1}, 32'd4);
    check("t6_write", {31'b0, pw1}, 32'd1);
    check("t6_epc", epc1, 32'h0);
    idle(2);

    // pc_in=0 wraps EPC; latency follows MEM_LAT.
    exc_divzero = 1'b1;
    pc_in = 32'h0;
    run_to_write(n1, n3);
    check("t7_lat1", n1, 32'd4);
    check("t7_lat3", n3, 32'd6);
    check("t7_epc1", epc1, 32'hFFFFFFFC);
    check("t7_epc3", epc3, 32'hFFFFFFFC);
    check("t7_cause3", {30'b0, cause3}, 32'd3);
    check("t7_mem_addr3", mem_addr3, 32'd255);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
